mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares the single simple_memory req/ready port between N_REQ cache controllers.
- Sits between the per-core MESI cache controllers and simple_memory.
- Latches one requester's transaction and sequences the memory handshake.
- Returns the read data and a one-cycle response pulse to the granted requester.
- Adds a watchdog that aborts a transaction when memory does not answer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max cycles in WAIT before abort (>=4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held until its resp_valid bit pulses.
- req_we  in  N_REQ  1 = write, 0 = read; stable while req_valid is high.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- resp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = timeout abort.
- resp_rdata  out  DATA_W  shared response data, valid with resp_valid.
- mem_req  out  1  to simple_memory.
- mem_we  out  1  to simple_memory.
- mem_addr  out  ADDR_W  to simple_memory.
- mem_wdata  out  DATA_W  to simple_memory.
- mem_rdata  in  DATA_W  from simple_memory.
- mem_ready  in  1  from simple_memory; single-cycle pulse.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(N_REQ)  index of current or last grant.

Behaviour:
- Reset (async, rst=1): every output, the pointer and the timer go to 0; state = IDLE.
  - Reset mid-transaction drops mem_req immediately.
  - No response is issued for the aborted transaction.
- All outputs are registered. There are three states: IDLE, WAIT and RECOVER.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo N_REQ.
  - The first set bit is granted. At that edge:
    - latch addr, wdata and we into mem_addr, mem_wdata and mem_we;
    - mem_req <= 1, grant_id <= index, timer <= 0;
    - rr_ptr <= (index+1) mod N_REQ;
    - state <= WAIT.
  - If no bit is set, stay in IDLE; rr_ptr is unchanged.
- WAIT:
  - mem_req is held high; mem_addr, mem_wdata and mem_we are held constant.
  - On mem_ready=1:
    - mem_req <= 0;
    - resp_valid[grant_id] <= 1, resp_err <= 0;
    - resp_rdata <= mem_rdata; for writes this is the echoed write data;
    - state <= RECOVER.
  - Else, if timer == TIMEOUT-1:
    - mem_req <= 0;
    - resp_valid[grant_id] <= 1, resp_err <= 1;
    - resp_rdata <= 0;
    - state <= RECOVER.
  - Else timer <= timer+1.
- RECOVER (exactly 1 cycle):
  - resp_valid <= 0, resp_err <= 0; state <= IDLE.
  - This cycle lets memory clear mem_ready and its delay counter.
  - It also lets the served requester drop req_valid before the next arbitration.
- Latency against simple_memory (3-cycle delay):
  - req_valid high in IDLE at cycle 0 → mem_req high at cycle 1 → mem_ready at cycle 4 → resp_valid at cycle 5.
  - Next grant can occur at cycle 6, so back-to-back service is one transaction per 6 cycles.
- Boundary conditions:
  - mem_ready seen in IDLE or RECOVER (stale or late after a timeout) is ignored.
  - req_valid deasserted by a requester while granted is ignored; the transaction completes and is reported.
  - Simultaneous requests are resolved only by rr_ptr. No requester waits more than N_REQ-1 grants.
  - rr_ptr wraps from N_REQ-1 to 0.
  - resp_valid is never multi-hot and never asserted outside RECOVER entry.

Test Plan:
- Single read: requester 1 reads addr 0x10 on initialized memory (word 4 = 0x4) → mem_req high cycles 1–4, resp_valid = 4'b0010 at cycle 5, resp_rdata = 0x4, resp_err = 0, busy low at cycle 6.
- Write then read: requester 0 writes 0xDEADBEEF to 0x20, then reads 0x20 → both complete, read returns 0xDEADBEEF, mem_we = 1 only during the write's WAIT.
- Fairness: all 4 req_valid held continuously from reset → grant order 0,1,2,3,0 with grant_id changing every 6 cycles, each resp_valid bit one-hot.
- Timeout: memory model with mem_ready tied 0, TIMEOUT = 16 → mem_req high exactly 16 cycles, then resp_valid[g] = 1 with resp_err = 1 and resp_rdata = 0; a late mem_ready pulse in IDLE is ignored.
- Reset mid-WAIT: rst asserted 2 cycles after grant → mem_req, resp_valid and busy go to 0 asynchronously, no response pulse; after release, rr_ptr = 0 and the pending requester 0 is re-granted.
- Idle/pointer hold: requests only from requester 3, repeated 3 times → each served at 6-cycle intervals, rr_ptr stays at 0 after each grant, no spurious mem_req between transactions.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one memory req/ready port among N_REQ requesters, with a watchdog abort.
// Grant lands one cycle after a request; response pulses one cycle after mem_ready/timeout; requesters hold req_valid until served.
`timescale 1ns/1ps
module mem_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_err,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id
);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RECOVER} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [TMR_W-1:0] timer;
    logic             pick_vld;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  next_ptr;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return ID_W'(sum);
    endfunction

    // First set request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && req_valid[wrap_idx(rr_ptr, k)]) begin
                pick_vld = 1'b1;
                pick_id  = wrap_idx(rr_ptr, k);
            end
        end
    end

    assign next_ptr = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            timer      <= '0;
            grant_id   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        mem_addr  <= req_addr[pick_id*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[pick_id*DATA_W +: DATA_W];
                        mem_we    <= req_we[pick_id];
                        mem_req   <= 1'b1;
                        grant_id  <= pick_id;
                        timer     <= '0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= N_REQ'(1) << grant_id;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_rdata;
                        state      <= RECOVER;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= N_REQ'(1) << grant_id;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RECOVER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RECOVER: begin
                    // One dead cycle so memory and the served requester settle before re-arbitration.
                    resp_valid <= '0;
                    resp_err   <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: 3-cycle memory model, transaction-level reference model, directed scenarios.
`timescale 1ns/1ps
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            resp_err, mem_req, mem_we, mem_ready, busy;
    logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      grant_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
    );

    // Memory: word i initialised to i, ready pulse after 3 cycles of mem_req, writes echo wdata.
    logic [31:0] mem_arr [0:63];
    logic [1:0]  mcnt;
    logic        mem_ready_q, mem_en, late_pulse;
    assign mem_ready = mem_ready_q | late_pulse;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'(i);
            mcnt        <= 2'd0;
            mem_ready_q <= 1'b0;
            mem_rdata   <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            if (mem_req && !mem_ready_q && mem_en) begin
                if (mcnt == 2'd2) begin
                    mcnt        <= 2'd0;
                    mem_ready_q <= 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr[7:2]] <= mem_wdata;
                        mem_rdata              <= mem_wdata;
                    end else begin
                        mem_rdata <= mem_arr[mem_addr[7:2]];
                    end
                end else begin
                    mcnt <= mcnt + 2'd1;
                end
            end else begin
                mcnt <= 2'd0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no DUT response within cycle budget (got none, required one)", name);
    endtask

    // Reference model: one outstanding transaction; owner chosen by scanning from the pointer.
    int          m_ptr = 0, m_gid = 0, m_age = 0;
    bit          m_active = 0, m_resp = 0, m_err = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    initial begin
        int j;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ptr = 0; m_gid = 0; m_age = 0; m_active = 0; m_resp = 0; m_err = 0;
                m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if (m_resp) begin
                m_resp = 0;
                m_err  = 0;
            end else if (m_active) begin
                if (mem_ready) begin
                    m_active = 0; m_resp = 1; m_err = 0; m_we = 0; m_rdata = mem_rdata;
                end else if (m_age == TO - 1) begin
                    m_active = 0; m_resp = 1; m_err = 1; m_we = 0; m_rdata = '0;
                end else begin
                    m_age++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!m_active && req_valid[j]) begin
                        m_active = 1;
                        m_gid    = j;
                        m_age    = 0;
                        m_we     = req_we[j];
                        m_addr   = req_addr[j*AW +: AW];
                        m_wdata  = req_wdata[j*DW +: DW];
                    end
                end
                if (m_active) m_ptr = (m_gid + 1) % N;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_mem_req", mem_req, m_active);
            chk("cmp_mem_we", mem_we, m_we);
            chk("cmp_mem_addr", mem_addr, m_addr);
            chk("cmp_mem_wdata", mem_wdata, m_wdata);
            chk("cmp_resp_valid", resp_valid, m_resp ? (64'd1 << m_gid) : 64'd0);
            chk("cmp_resp_err", resp_err, m_err);
            chk("cmp_busy", busy, m_active || m_resp);
            chk("cmp_grant_id", grant_id, m_gid);
            if (m_resp) chk("cmp_resp_rdata", resp_rdata, m_rdata);
        end
    end

    int got_id [0:7];
    int got_t  [0:7];

    task automatic do_txn(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err, output int req_cycles);
        bit got;
        got = 0;
        req_cycles = 0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = wd;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                chk("txn_we_wait", mem_we, we);
            end else begin
                chk("txn_we_outside", mem_we, 0);
            end
            if (resp_valid != 0) got = 1;
        end
        if (!got) bound_fail("txn_resp");
        chk("txn_resp_valid", resp_valid, 64'd1 << i);
        chk("txn_resp_rdata", resp_rdata, exp_rd);
        chk("txn_resp_err", resp_err, exp_err);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_we[i] = 1'b0;
    endtask

    task automatic hold_collect(input logic [N-1:0] mask, input int n);
        int got;
        got = 0;
        @(posedge clk); #1;
        req_valid = mask;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            if (resp_valid != 0) begin
                chk("collect_onehot", $countones(resp_valid), 1);
                for (int b = 0; b < N; b++) if (resp_valid[b]) got_id[got] = b;
                got_t[got] = cyc;
                got++;
            end
        end
        if (got < n) bound_fail("collect_resp");
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        int rc;
        int exp_order [0:4];
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_en = 1'b1; late_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_rr_ptr", dut.rr_ptr, 0);

        // Single read from requester 1, cycle-exact.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1*AW +: AW] = 32'h10;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 6) req_valid[1] = 1'b0;
            @(negedge clk);
            if (c <= 4) chk("rd_mem_req_high", mem_req, 1);
            if (c == 1) chk("rd_grant_id", grant_id, 1);
            if (c == 1) chk("rd_mem_addr", mem_addr, 32'h10);
            if (c == 5) begin
                chk("rd_resp_valid", resp_valid, 4'b0010);
                chk("rd_resp_rdata", resp_rdata, 32'h4);
                chk("rd_resp_err", resp_err, 0);
                chk("rd_mem_req_low", mem_req, 0);
            end
            if (c == 6) chk("rd_busy_low", busy, 0);
        end

        // Write then read back through requester 0.
        do_txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, rc);
        chk("wr_req_cycles", rc, 4);
        do_txn(0, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, rc);
        chk("rd_back_req_cycles", rc, 4);

        // Fairness: all requesters held from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'(i * 4);
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hold_collect(4'hF, 5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", got_id[k], exp_order[k]);
            if (k > 0) chk("fair_interval", got_t[k] - got_t[k-1], 6);
        end

        // Watchdog: memory never answers.
        mem_en = 1'b0;
        do_txn(2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, rc);
        chk("to_req_cycles", rc, TO);
        mem_en = 1'b1;
        late_pulse = 1'b1;
        @(posedge clk); #1;
        late_pulse = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late_ready_mem_req", mem_req, 0);
            chk("late_ready_resp", resp_valid, 0);
        end

        // Only requester 3: pointer wraps back to 0 after every grant.
        req_addr[3*AW +: AW] = 32'h30;
        hold_collect(4'h8, 3);
        for (int k = 0; k < 3; k++) chk("hold_id", got_id[k], 3);
        for (int k = 1; k < 3; k++) chk("hold_interval", got_t[k] - got_t[k-1], 6);
        chk("hold_rr_ptr", dut.rr_ptr, 0);

        // Reset two cycles into WAIT, then re-grant of requester 0.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0*AW +: AW] = 32'h8;
        rc = 0;
        for (int c = 0; c < 10 && rc == 0; c++) begin
            @(negedge clk);
            if (mem_req) rc = 1;
        end
        if (rc == 0) bound_fail("rstw_grant");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_resp_valid", resp_valid, 0);
        chk("rstw_rr_ptr", dut.rr_ptr, 0);
        @(posedge clk); #1 rst = 1'b0;
        rc = 0;
        for (int c = 0; c < 20 && rc == 0; c++) begin
            @(negedge clk);
            if (resp_valid != 0) rc = 1;
        end
        if (rc == 0) bound_fail("rstw_regrant");
        chk("rstw_regrant_id", grant_id, 0);
        chk("rstw_regrant_resp", resp_valid, 4'b0001);
        chk("rstw_regrant_rdata", resp_rdata, 32'h2);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running (required completion)");
        $fatal(1);
    end
endmodule
